counter_sync_updown_mod: RTL

Parametrised synchronous up/down modulo counter, the next-generation replacement for the fixed 4-bit ripple up-counter. All bits change on the same clock edge, so there is no ripple skew. The block adds:
- configurable width and modulus
- count direction control
- parallel load and count enable
- wrap or saturate mode
- terminal-count and wrap flags for cascading

It serves as the general-purpose counter primitive for dividers, timers and address generators.

---
 rtl/counter_sync_updown_mod.sv | 76 +++++++
 1 files changed

// File: rtl/counter_sync_updown_mod.sv
// Synchronous up/down modulo counter with load, enable, wrap/saturate and cascade flags.
// State updates on the falling edge of Clk; Clr clears asynchronously.
module counter_sync_updown_mod #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] count,
  output logic             Tc,
  output logic             Wrap
);

  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic [WIDTH-1:0] w_next_count;
  logic             w_next_wrap;
  logic             w_at_max;
  logic             w_at_zero;

  assign w_at_max  = (r_count == LP_MAX);
  assign w_at_zero = (r_count == '0);

  always_comb begin
    w_next_count = r_count;
    w_next_wrap  = 1'b0;
    if (Load) begin
      w_next_count = (Din > LP_MAX) ? LP_MAX : Din;
    end else if (En) begin
      if (Up) begin
        if (w_at_max) begin
          if (!SATURATE) begin
            w_next_count = '0;
            w_next_wrap  = 1'b1;
          end
        end else if (r_count < LP_MAX) begin
          w_next_count = r_count + WIDTH'(1);
        end else begin
          // an out-of-range value recovers to zero without flagging a wrap
          w_next_count = '0;
        end
      end else begin
        if (w_at_zero) begin
          if (!SATURATE) begin
            w_next_count = LP_MAX;
            w_next_wrap  = 1'b1;
          end
        end else begin
          w_next_count = r_count - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(negedge Clk or posedge Clr) begin
    if (Clr) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_wrap  <= w_next_wrap;
    end
  end

  assign count = r_count;
  assign Wrap  = r_wrap;
  assign Tc    = En & (Up ? w_at_max : w_at_zero);

endmodule
